// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder computing a + b + cin over WIDTH clocks,
// one bit per clock, LSB first. A single full-adder cell with a registered
// carry does the arithmetic. A start/busy/done handshake sequences each
// operation.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] psum;

  logic             ha1_s;
  logic             ha1_c;
  logic             ha2_s;
  logic             ha2_c;
  logic             c_next;
  logic [WIDTH-1:0] psum_next;
  logic             last_bit;

  // Full-adder cell on the current LSBs: two half adders plus OR.
  always_comb begin
    ha1_s  = areg[0] ^ breg[0];
    ha1_c  = areg[0] & breg[0];
    ha2_s  = ha1_s ^ carry;
    ha2_c  = ha1_s & carry;
    c_next = ha1_c | ha2_c;
    // Shift right, then drop the new sum bit into the MSB. This form also
    // holds for WIDTH=1, where the shifted-in bit is the whole result.
    psum_next            = psum >> 1;
    psum_next[WIDTH-1]   = ha2_s;
    last_bit             = (cnt == CW'(WIDTH - 1));
  end

  // Sequencer and datapath registers. The results change only on DONE entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      areg  <= '0;
      breg  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      psum  <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            areg  <= a;
            breg  <= b;
            carry <= cin;
            psum  <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          areg  <= areg >> 1;
          breg  <= breg >> 1;
          carry <= c_next;
          psum  <= psum_next;
          if (last_bit) begin
            sum   <= psum_next;
            cout  <= c_next;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Handshake outputs decode directly from the registered state.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vectors and randomized checks for serial_adder
// at WIDTH=8, 4 and 1, against plain-arithmetic expectations a + b + cin.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // WIDTH=8 instance
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  // WIDTH=4 instance
  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       cin4 = 1'b0;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  // WIDTH=1 instance
  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       cin1 = 1'b0;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec8_t;

  typedef struct {
    logic a;
    logic b;
    logic cin;
    logic sum;
    logic cout;
  } vec1_t;

  logic [8:0] last8 = '0;

  task automatic chk(input string name, input logic [64:0] got, input logic [64:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // One WIDTH=8 operation with a single-cycle start pulse.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic [8:0] exp);
    int n;
    bit busy_ok;
    bit hold_ok;
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    n = 1; busy_ok = 1'b1; hold_ok = 1'b1;
    while (!done8 && n <= 40) begin
      if (!busy8) busy_ok = 1'b0;
      if ({cout8, sum8} !== last8) hold_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("w8_latency", 65'(n), 65'(9));
    chk("w8_busy_during_run", 65'(busy_ok), 65'(1));
    chk("w8_hold_during_run", 65'(hold_ok), 65'(1));
    chk("w8_result", 65'({cout8, sum8}), 65'(exp));
    chk("w8_busy_low_in_done", 65'(busy8), 65'(0));
    last8 = exp;
    @(negedge clk);
    chk("w8_done_single_pulse", 65'(done8), 65'(0));
    chk("w8_hold_idle", 65'({cout8, sum8}), 65'(last8));
  endtask

  task automatic run1(input logic a, input logic b, input logic c, input logic [1:0] exp);
    int n;
    @(negedge clk);
    a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    a1 = ~a; b1 = ~b; cin1 = ~c;
    n = 1;
    while (!done1 && n <= 10) begin
      @(negedge clk);
      n++;
    end
    chk("w1_latency", 65'(n), 65'(2));
    chk("w1_result", 65'({cout1, sum1}), 65'(exp));
  endtask

  vec8_t v8[7];
  vec1_t v1[8];

  initial begin
    v8[0] = '{a: 8'h00, b: 8'h00, cin: 1'b0, sum: 8'h00, cout: 1'b0};
    v8[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1};
    v8[2] = '{a: 8'hA5, b: 8'h5A, cin: 1'b1, sum: 8'h00, cout: 1'b1};
    v8[3] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, sum: 8'h80, cout: 1'b0};
    v8[4] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1};
    v8[5] = '{a: 8'h0F, b: 8'hF0, cin: 1'b0, sum: 8'hFF, cout: 1'b0};
    v8[6] = '{a: 8'h12, b: 8'h34, cin: 1'b1, sum: 8'h47, cout: 1'b0};

    v1[0] = '{a: 1'b0, b: 1'b0, cin: 1'b0, sum: 1'b0, cout: 1'b0};
    v1[1] = '{a: 1'b0, b: 1'b0, cin: 1'b1, sum: 1'b1, cout: 1'b0};
    v1[2] = '{a: 1'b0, b: 1'b1, cin: 1'b0, sum: 1'b1, cout: 1'b0};
    v1[3] = '{a: 1'b0, b: 1'b1, cin: 1'b1, sum: 1'b0, cout: 1'b1};
    v1[4] = '{a: 1'b1, b: 1'b0, cin: 1'b0, sum: 1'b1, cout: 1'b0};
    v1[5] = '{a: 1'b1, b: 1'b0, cin: 1'b1, sum: 1'b0, cout: 1'b1};
    v1[6] = '{a: 1'b1, b: 1'b1, cin: 1'b0, sum: 1'b0, cout: 1'b1};
    v1[7] = '{a: 1'b1, b: 1'b1, cin: 1'b1, sum: 1'b1, cout: 1'b1};

    // Reset state
    #2;
    chk("reset_busy8", 65'(busy8), 65'(0));
    chk("reset_done8", 65'(done8), 65'(0));
    chk("reset_result8", 65'({cout8, sum8}), 65'(0));
    chk("reset_handshake4_1", 65'({busy4, done4, busy1, done1}), 65'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed WIDTH=8 vectors
    for (int i = 0; i < 7; i++)
      run8(v8[i].a, v8[i].b, v8[i].cin, {v8[i].cout, v8[i].sum});

    // Start pulsed again mid-RUN must be ignored
    begin
      int n;
      int extra;
      @(negedge clk);
      a8 = 8'h3C; b8 = 8'h42; cin8 = 1'b0; start8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0;
      n = 1;
      while (!done8 && n <= 40) begin
        if (n == 3) begin
          a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        end else begin
          start8 = 1'b0;
        end
        @(negedge clk);
        n++;
      end
      start8 = 1'b0;
      chk("ignored_start_latency", 65'(n), 65'(9));
      chk("ignored_start_result", 65'({cout8, sum8}), 65'(9'h07E));
      last8 = 9'h07E;
      extra = 0;
      repeat (12) begin
        @(negedge clk);
        if (done8) extra++;
      end
      chk("ignored_start_no_extra_done", 65'(extra), 65'(0));
    end

    // Asynchronous reset in the middle of RUN
    begin
      int bad;
      @(negedge clk);
      a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      chk("midrun_busy_before_reset", 65'(busy8), 65'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("midrun_reset_busy", 65'(busy8), 65'(0));
      chk("midrun_reset_done", 65'(done8), 65'(0));
      chk("midrun_reset_result", 65'({cout8, sum8}), 65'(0));
      bad = 0;
      repeat (4) begin
        @(negedge clk);
        if (done8 || busy8) bad++;
      end
      rst_n = 1'b1;
      repeat (10) begin
        @(negedge clk);
        if (done8) bad++;
      end
      chk("midrun_no_done_pulse", 65'(bad), 65'(0));
      last8 = '0;
      run8(8'h12, 8'h34, 1'b1, 9'h047);
    end

    // Randomized WIDTH=8 operations against a + b + cin
    repeat (20) begin
      logic [7:0] ra, rb;
      logic       rc;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      run8(ra, rb, rc, 9'(ra) + 9'(rb) + 9'(rc));
    end

    // WIDTH=1 full-adder truth table
    for (int i = 0; i < 8; i++)
      run1(v1[i].a, v1[i].b, v1[i].cin, {v1[i].cout, v1[i].sum});

    // WIDTH=4 exhaustive, start held high, back-to-back
    begin
      int idx;
      int cyc;
      int prev;
      logic [8:0] op;
      op = '0;
      @(negedge clk);
      a4 = op[3:0]; b4 = op[7:4]; cin4 = op[8]; start4 = 1'b1;
      idx = 0; cyc = 0; prev = -1;
      while (idx < 512 && cyc < 512 * 6 + 50) begin
        @(negedge clk);
        cyc++;
        if (done4) begin
          chk("w4_result", 65'({cout4, sum4}), 65'(5'(a4) + 5'(b4) + 5'(cin4)));
          if (prev >= 0) chk("w4_spacing", 65'(cyc - prev), 65'(6));
          prev = cyc;
          idx++;
          if (idx < 512) begin
            op = 9'(idx);
            a4 = op[3:0]; b4 = op[7:4]; cin4 = op[8];
          end
        end
      end
      start4 = 1'b0;
      chk("w4_all_results_seen", 65'(idx), 65'(512));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised bit-serial adder: computes a + b + cin for WIDTH-bit operands, one bit per clock, LSB first.
- The datapath is a single full-adder cell (two half-adder stages plus OR) with a registered carry.
- Sits between operand registers and result consumers in the DSD arithmetic blocks, trading latency for area.
- Operation uses a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..64.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  reset, asynchronous assert, active-low
- start  input  1  request an addition; sampled only in IDLE
- a  input  WIDTH  operand A, captured on the accepting edge
- b  input  WIDTH  operand B, captured on the accepting edge
- cin  input  1  carry-in, captured on the accepting edge
- busy  output  1  high while an addition is in progress (RUN)
- done  output  1  single-cycle pulse: result valid
- sum  output  WIDTH  registered result, low WIDTH bits of a+b+cin
- cout  output  1  registered carry-out, bit WIDTH of a+b+cin

Behaviour:
- Clocking and reset: one clock (clk). Reset rst_n is asynchronous and active-low.
- While rst_n=0:
  - state=IDLE
  - busy=0, done=0, sum=0, cout=0
  - internal operand shift registers, carry flop, bit counter and partial-sum register all cleared.
- State machine: IDLE, RUN, DONE.
  - IDLE: busy=0, done=0. On an edge with start=1: load a, b and carry flop←cin; clear partial sum; bit counter←0; go to RUN. With start=0, stay in IDLE.
  - RUN: busy=1. Each edge processes the current LSBs ai, bi and carry c:
    - s = ai^bi^c
    - c_next = (ai&bi) | (c&(ai^bi))
    - s shifts into the partial-sum MSB; partial sum shifts right by one.
    - Operands shift right by one; counter increments.
    - On the edge processing bit WIDTH-1: sum←completed partial sum, cout←c_next, go to DONE.
  - DONE: busy=0, done=1 for exactly one cycle. Next edge returns to IDLE unconditionally.
- Latency:
  - Start accepted at edge E0.
  - busy=1 for cycles after E0 through E_WIDTH.
  - done=1 in the cycle after E_WIDTH.
  - Total: done asserted WIDTH+1 cycles after E0; back-to-back throughput is one result per WIDTH+2 cycles.
- start handling:
  - Ignored in RUN and DONE. Operands are not re-captured and there is no queuing.
  - start held high continuously gives back-to-back operations: IDLE accepts on the first edge after DONE.
- Output stability:
  - sum and cout change only on the DONE-entry edge.
  - They hold the last result through IDLE and through the next operation until that operation completes.
  - a, b and cin may change freely after the accepting edge.
- Width rules:
  - The counter is sized to hold values 0..WIDTH-1.
  - The full result is {cout, sum}, exactly WIDTH+1 bits. There is no overflow flag and no signed interpretation.
- WIDTH=1: RUN lasts one edge, so done comes 2 cycles after start. The block then behaves as a registered full adder.
- Reset mid-operation:
  - rst_n low during RUN or DONE aborts immediately. All outputs go to 0, including the held sum and cout.
  - No done pulse is produced for the aborted operation.
  - The first start after reset release behaves normally.

Test Plan:
- WIDTH=8, reset then a=0x00, b=0x00, cin=0, start one cycle -> busy=1 for 8 cycles, then done=1 for 1 cycle with sum=0x00, cout=0; done asserted 9 cycles after the start edge.
- WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1. sum/cout hold 0x00/1 between done pulses.
- WIDTH=8, a=0x3C, b=0x42, start; pulse start again with a=0xFF, b=0xFF at cycle 3 of RUN -> second request ignored; result sum=0x7E, cout=0. Exactly one done pulse.
- WIDTH=8, a=0x80, b=0x80, start; assert rst_n=0 after 4 RUN cycles -> busy, done, sum, cout go 0 without waiting for clk; no done pulse. After release, a=0x12, b=0x34, cin=1 -> sum=0x47, cout=0.
- WIDTH=4, exhaustive a, b in 0..15, cin in {0,1}, start held high -> every done pulse has {cout,sum}=a+b+cin. Pulses are spaced exactly 6 cycles apart.
- WIDTH=1, all 8 combinations of a, b, cin -> {cout,sum} matches the full-adder truth table (e.g. 1,1,1 -> cout=1, sum=1); done comes 2 cycles after start.
